sd_card_dat_phys: RTL and testbench

- Card-side physical layer for the single-bit SD DAT line; the far end of the host DAT PHY.
- Read transfer (card to host): fetches 32-bit words from a card data source and serialises 50-bit frames onto DAT.
- Write transfer (host to card): deserialises 50-bit frames from DAT, delivers the 32-bit payload and answers each block with a 3-bit response token.
- Used as the card model in host-controller system benches and as the DAT front end of the card emulator.

---
 rtl/sd_card_dat_phys.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sd_card_dat_phys.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_card_dat_phys.sv
// ---------------------------------------------------------------------------
// sd_card_dat_phys
//
// Card-side physical layer for a single-bit SD DAT line.
//   Read  (card -> host): fetch 32-bit words and serialise 50-bit frames.
//   Write (host -> card): deserialise 50-bit frames, deliver the payload and
//                         answer each block with a 3-bit response token.
//
// Frame, MSB first: start(0) | payload[31:0] | crc[15:0]=0 | end(1)
//
// Ports
//   sd_clock     in   1   clock, one DAT bit per cycle
//   reset        in   1   asynchronous, active-low reset
//   start_read   in   1   pulse, begin a read transfer
//   start_write  in   1   pulse, begin a write transfer
//   blocks       in   4   block count when multiple=1 (0 counts as 1)
//   multiple     in   1   1 = use blocks, 0 = single block
//   timeout_reg  in  16   max cycles to wait for a write start bit
//   tx_data      in  32   word to transmit
//   tx_valid     in   1   tx_data available
//   tx_ready     out  1   tx_data consumed this cycle
//   rx_data      out 32   payload of the last good write frame
//   rx_valid     out  1   pulse, rx_data is new
//   dat_in       in   1   sampled DAT line
//   dat_out      out  1   driven DAT value
//   dat_oe       out  1   1 = card drives DAT
//   busy         out  1   transfer in progress
//   done         out  1   pulse, transfer finished
//   frame_error  out  1   pulse, bad write frame
//   timeout      out  1   pulse, start-bit timeout
// ---------------------------------------------------------------------------
module sd_card_dat_phys #(
  parameter int         GAP_CYCLES = 2,
  parameter logic [2:0] TOKEN_OK   = 3'b010,
  parameter logic [2:0] TOKEN_ERR  = 3'b101
) (
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        start_read,
  input  logic        start_write,
  input  logic [3:0]  blocks,
  input  logic        multiple,
  input  logic [15:0] timeout_reg,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        dat_in,
  output logic        dat_out,
  output logic        dat_oe,
  output logic        busy,
  output logic        done,
  output logic        frame_error,
  output logic        timeout
);

  typedef enum logic [3:0] {
    IDLE, TX_FETCH, TX_SHIFT, TX_GAP,
    RX_WAIT, RX_SHIFT, RX_GAP, RX_TOKEN, FINISH
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t      state;
  logic [48:0] tx_sr;
  logic [47:0] rx_sr;
  logic [5:0]  bit_cnt;
  logic [7:0]  gap_cnt;
  logic [1:0]  tok_cnt;
  logic [1:0]  tok_sr;
  logic [15:0] wait_cnt;
  logic [3:0]  blk_cnt;
  logic [3:0]  blk_target;
  logic        bad_frame;

  logic [3:0]  target_sel;
  logic        last_block;
  logic [16:0] wait_next;
  logic        timed_out;
  logic [2:0]  tok_word;

  // The word is consumed in the same cycle it is offered while fetching.
  assign tx_ready   = (state == TX_FETCH) && tx_valid;

  assign target_sel = (multiple && (blocks != 4'd0)) ? blocks : 4'd1;
  // blk_cnt counts completed blocks, so the block in flight is the last one
  // when one more completion reaches the target.
  assign last_block = ({1'b0, blk_cnt} + 5'd1) >= {1'b0, blk_target};

  // Timeout compares the post-increment count, so a limit of 0 or 1 both
  // expire after the first wait cycle.
  assign wait_next  = {1'b0, wait_cnt} + 17'd1;
  assign timed_out  = wait_next >= {1'b0, timeout_reg};

  assign tok_word   = bad_frame ? TOKEN_ERR : TOKEN_OK;

  // Single FSM; all outputs except tx_ready are registered. Pulse outputs
  // default low every cycle and are raised only for the cycle they report.
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      tok_cnt     <= '0;
      tok_sr      <= '0;
      wait_cnt    <= '0;
      blk_cnt     <= '0;
      blk_target  <= '0;
      bad_frame   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      dat_out     <= 1'b1;
      dat_oe      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_error <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      timeout     <= 1'b0;
      done        <= 1'b0;

      case (state)
        IDLE: begin
          // start_read has priority when both starts arrive together.
          if (start_read) begin
            state      <= TX_FETCH;
            busy       <= 1'b1;
            dat_oe     <= 1'b1;
            dat_out    <= 1'b1;
            blk_cnt    <= '0;
            blk_target <= target_sel;
          end else if (start_write) begin
            state      <= RX_WAIT;
            busy       <= 1'b1;
            dat_oe     <= 1'b0;
            dat_out    <= 1'b1;
            blk_cnt    <= '0;
            blk_target <= target_sel;
            wait_cnt   <= '0;
            bad_frame  <= 1'b0;
          end
        end

        TX_FETCH: begin
          // Start bit goes straight to the pin; the rest waits in tx_sr.
          if (tx_valid) begin
            tx_sr   <= {tx_data, 16'h0000, 1'b1};
            dat_out <= 1'b0;
            bit_cnt <= '0;
            state   <= TX_SHIFT;
          end
        end

        TX_SHIFT: begin
          if (bit_cnt == 6'd49) begin
            blk_cnt <= blk_cnt + 4'd1;
            dat_out <= 1'b1;
            gap_cnt <= '0;
            if (last_block) begin
              dat_oe <= 1'b0;
              state  <= FINISH;
            end else begin
              state  <= TX_GAP;
            end
          end else begin
            dat_out <= tx_sr[48];
            tx_sr   <= {tx_sr[47:0], 1'b0};
            bit_cnt <= bit_cnt + 6'd1;
          end
        end

        TX_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= TX_FETCH;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        RX_WAIT: begin
          // A low line wins over an expiring timeout in the same cycle.
          if (!dat_in) begin
            bit_cnt <= '0;
            state   <= RX_SHIFT;
          end else if (timed_out) begin
            timeout <= 1'b1;
            state   <= FINISH;
          end else begin
            wait_cnt <= wait_next[15:0];
          end
        end

        RX_SHIFT: begin
          // After 48 samples rx_sr holds frame bits 48..1; dat_in is the end bit.
          rx_sr <= {rx_sr[46:0], dat_in};
          if (bit_cnt == 6'd48) begin
            if (dat_in) begin
              rx_data  <= rx_sr[47:16];
              rx_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
              bad_frame   <= 1'b1;
            end
            gap_cnt <= '0;
            state   <= RX_GAP;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end

        RX_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            dat_oe  <= 1'b1;
            dat_out <= tok_word[2];
            tok_sr  <= tok_word[1:0];
            tok_cnt <= '0;
            state   <= RX_TOKEN;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        RX_TOKEN: begin
          if (tok_cnt == 2'd2) begin
            dat_oe  <= 1'b0;
            dat_out <= 1'b1;
            blk_cnt <= blk_cnt + 4'd1;
            // A bad frame abandons any remaining blocks.
            if (last_block || bad_frame) begin
              state <= FINISH;
            end else begin
              wait_cnt <= '0;
              state    <= RX_WAIT;
            end
          end else begin
            dat_out <= tok_sr[1];
            tok_sr  <= {tok_sr[0], 1'b0};
            tok_cnt <= tok_cnt + 2'd1;
          end
        end

        FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          dat_oe  <= 1'b0;
          dat_out <= 1'b1;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_card_dat_phys.sv
// ---------------------------------------------------------------------------
// tb_sd_card_dat_phys
//
// Self-checking bench for sd_card_dat_phys. Reads are checked by decoding the
// DAT stream back into frames and comparing against frames built from the
// words offered; writes are checked by acting as the host and comparing the
// delivered payloads, error pulses and response tokens against expectations
// derived from the block count and which frame carries a bad end bit.
// ---------------------------------------------------------------------------
module tb_sd_card_dat_phys;

  localparam int GAP   = 2;
  localparam int LIMIT = 3000;

  logic        sd_clock = 1'b0;
  logic        reset;
  logic        start_read;
  logic        start_write;
  logic [3:0]  blocks;
  logic        multiple;
  logic [15:0] timeout_reg;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        dat_in;
  logic        dat_out;
  logic        dat_oe;
  logic        busy;
  logic        done;
  logic        frame_error;
  logic        timeout;

  sd_card_dat_phys #(.GAP_CYCLES(GAP), .TOKEN_OK(3'b010), .TOKEN_ERR(3'b101)) dut (
    .sd_clock    (sd_clock),
    .reset       (reset),
    .start_read  (start_read),
    .start_write (start_write),
    .blocks      (blocks),
    .multiple    (multiple),
    .timeout_reg (timeout_reg),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .dat_in      (dat_in),
    .dat_out     (dat_out),
    .dat_oe      (dat_oe),
    .busy        (busy),
    .done        (done),
    .frame_error (frame_error),
    .timeout     (timeout)
  );

  always #5 sd_clock = ~sd_clock;

  int n_vec  = 0;
  int n_miss = 0;

  // Values applied just after the next rising edge.
  logic        nxt_start_read  = 1'b0;
  logic        nxt_start_write = 1'b0;
  logic        nxt_tx_valid    = 1'b0;
  logic [31:0] nxt_tx_data     = 32'h0;
  logic        nxt_dat_in      = 1'b1;

  logic [31:0] words[$];
  int          stalls[$];
  logic        bit_q[$];
  logic [31:0] exp_rx_data = 32'h0;

  typedef struct {
    logic       is_write;
    logic [3:0] blk;
    logic       mult;
    int         exp_blocks;
  } vec_t;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock period: drive inputs after the edge, sample mid-cycle.
  task automatic apply_stimulus();
    @(posedge sd_clock);
    #1;
    start_read  = nxt_start_read;
    start_write = nxt_start_write;
    tx_valid    = nxt_tx_valid;
    tx_data     = nxt_tx_data;
    dat_in      = nxt_dat_in;
    @(negedge sd_clock);
  endtask

  task automatic settle(input string name);
    nxt_start_read  = 1'b0;
    nxt_start_write = 1'b0;
    nxt_tx_valid    = 1'b0;
    nxt_dat_in      = 1'b1;
    apply_stimulus();
    apply_stimulus();
    check_output(name, 64'({done, busy, dat_oe}), 64'(3'b000));
  endtask

  // Read transfer: words[] are offered in order; stalls[k] is how many
  // cycles tx_valid stays low after frame k finishes.
  task automatic run_read(input logic [3:0] blk, input logic mult, input int n_exp);
    int          ready_cnt = 0, frames = 0, done_cnt = 0, bit_idx = 0;
    int          gap_run = 0, stall_left = 0, last_stall = 0, widx = 0, exp_gap;
    logic        in_frame = 1'b0;
    logic [49:0] cap = '0;
    logic [49:0] exp_frame;
    blocks          = blk;
    multiple        = mult;
    nxt_start_read  = 1'b1;
    nxt_tx_valid    = 1'b1;
    nxt_tx_data     = words[0];
    for (int c = 0; c < LIMIT && done_cnt == 0; c++) begin
      apply_stimulus();
      nxt_start_read = 1'b0;
      if (c == 1) check_output("rd_busy_rise", 64'({busy, dat_oe}), 64'(2'b11));
      if (tx_ready) begin
        ready_cnt++;
        widx++;
      end
      if (dat_oe) begin
        if (in_frame) begin
          cap = {cap[48:0], dat_out};
          bit_idx++;
          if (bit_idx == 50) begin
            exp_frame = {1'b0, (frames < words.size()) ? words[frames] : 32'h0, 16'h0000, 1'b1};
            check_output("rd_frame", 64'(cap), 64'(exp_frame));
            frames++;
            in_frame   = 1'b0;
            gap_run    = 0;
            last_stall = (frames - 1 < stalls.size()) ? stalls[frames - 1] : 0;
            stall_left = last_stall;
          end
        end else if (dat_out == 1'b0) begin
          if (frames > 0) begin
            exp_gap = ((last_stall > GAP) ? last_stall : GAP) + 1;
            check_output("rd_gap", 64'(gap_run), 64'(exp_gap));
          end
          in_frame = 1'b1;
          cap      = '0;
          bit_idx  = 1;
        end else if (frames > 0) begin
          gap_run++;
        end
      end
      if (done) done_cnt++;
      nxt_tx_data = (widx < words.size()) ? words[widx] : 32'h0;
      if (stall_left > 0) begin
        nxt_tx_valid = 1'b0;
        stall_left--;
      end else begin
        nxt_tx_valid = 1'b1;
      end
    end
    check_output("rd_done_count", 64'(done_cnt), 64'd1);
    check_output("rd_frame_count", 64'(frames), 64'(n_exp));
    check_output("rd_ready_count", 64'(ready_cnt), 64'(n_exp));
    settle("rd_idle_after");
  endtask

  // Queue host bits for write frame k: stalls[k] idle cycles then the frame.
  task automatic enqueue_frame(input int k, input logic end_ok);
    logic [49:0] f;
    int d;
    d = (k < stalls.size()) ? stalls[k] : 0;
    f = {1'b0, words[k], 16'h0000, end_ok};
    for (int i = 0; i < d; i++) bit_q.push_back(1'b1);
    for (int i = 49; i >= 0; i--) bit_q.push_back(f[i]);
  endtask

  // Write transfer: frame bad_idx (if in range) carries a 0 end bit.
  task automatic run_write(input logic [3:0] blk, input logic mult, input int target, input int bad_idx);
    int         n_frames, n_good, rx_cnt = 0, fe_cnt = 0, to_cnt = 0, done_cnt = 0;
    int         tokens = 0, tok_n = 0, end_period = 0;
    logic [2:0] tok = '0;
    logic       has_bad;
    has_bad  = (bad_idx >= 0) && (bad_idx < target);
    n_frames = has_bad ? bad_idx + 1 : target;
    n_good   = has_bad ? n_frames - 1 : n_frames;
    bit_q.delete();
    blocks          = blk;
    multiple        = mult;
    timeout_reg     = 16'd1000;
    nxt_start_write = 1'b1;
    nxt_dat_in      = 1'b1;
    enqueue_frame(0, bad_idx != 0);
    for (int c = 0; c < LIMIT && done_cnt == 0; c++) begin
      apply_stimulus();
      nxt_start_write = 1'b0;
      if (c == 1) check_output("wr_busy_rise", 64'({busy, dat_oe}), 64'(2'b10));
      if (rx_valid) begin
        if (rx_cnt < words.size()) check_output("wr_payload", 64'(rx_data), 64'(words[rx_cnt]));
        rx_cnt++;
      end
      if (frame_error) fe_cnt++;
      if (timeout) to_cnt++;
      if (dat_oe) begin
        if (tok_n == 0) check_output("wr_token_delay", 64'(c), 64'(end_period + GAP + 1));
        tok = {tok[1:0], dat_out};
        tok_n++;
        if (tok_n == 3) begin
          check_output("wr_token", 64'(tok), 64'((tokens == bad_idx) ? 3'b101 : 3'b010));
          tokens++;
          tok_n = 0;
          if (tokens < n_frames) enqueue_frame(tokens, tokens != bad_idx);
        end
      end
      if (done) done_cnt++;
      if (bit_q.size() > 0) begin
        nxt_dat_in = bit_q.pop_front();
        if (bit_q.size() == 0) end_period = c + 1;
      end else begin
        nxt_dat_in = 1'b1;
      end
    end
    for (int k = 0; k < n_frames; k++) if (k != bad_idx) exp_rx_data = words[k];
    check_output("wr_done_count", 64'(done_cnt), 64'd1);
    check_output("wr_rx_valid_count", 64'(rx_cnt), 64'(n_good));
    check_output("wr_frame_error_count", 64'(fe_cnt), 64'(has_bad ? 1 : 0));
    check_output("wr_token_count", 64'(tokens), 64'(n_frames));
    check_output("wr_timeout_count", 64'(to_cnt), 64'd0);
    check_output("wr_rx_data_hold", 64'(rx_data), 64'(exp_rx_data));
    settle("wr_idle_after");
  endtask

  // Write with the line held idle until the start-bit wait expires.
  task automatic run_timeout(input logic [15:0] limit);
    int first_to = -1, to_cnt = 0, oe_seen = 0, done_cnt = 0, exp_idx;
    exp_idx         = ((limit == 16'd0) ? 1 : int'(limit)) + 1;
    blocks          = 4'd1;
    multiple        = 1'b0;
    timeout_reg     = limit;
    nxt_start_write = 1'b1;
    nxt_dat_in      = 1'b1;
    for (int c = 0; c < LIMIT && done_cnt == 0; c++) begin
      apply_stimulus();
      nxt_start_write = 1'b0;
      if (timeout) begin
        to_cnt++;
        if (first_to < 0) first_to = c;
      end
      if (dat_oe) oe_seen++;
      if (done) done_cnt++;
    end
    check_output("to_pulse_cycle", 64'(first_to), 64'(exp_idx));
    check_output("to_pulse_count", 64'(to_cnt), 64'd1);
    check_output("to_line_released", 64'(oe_seen), 64'd0);
    check_output("to_done_count", 64'(done_cnt), 64'd1);
    settle("to_idle_after");
  endtask

  task automatic reset_mid_frame();
    int   bit_idx = 0, done_cnt = 0, oe_cnt = 0;
    logic in_frame = 1'b0;
    logic reached = 1'b0;
    words.delete();
    stalls.delete();
    words.push_back($urandom);
    stalls.push_back(0);
    blocks         = 4'd1;
    multiple       = 1'b0;
    nxt_start_read = 1'b1;
    nxt_tx_valid   = 1'b1;
    nxt_tx_data    = words[0];
    for (int c = 0; c < 200 && !reached; c++) begin
      apply_stimulus();
      nxt_start_read = 1'b0;
      if (in_frame) bit_idx++;
      else if (dat_oe && dat_out == 1'b0) begin
        in_frame = 1'b1;
        bit_idx  = 1;
      end
      if (bit_idx == 25) reached = 1'b1;
    end
    check_output("rst_reached_bit25", 64'(reached), 64'd1);
    reset = 1'b0;
    #1;
    check_output("rst_line_release", 64'({dat_oe, dat_out, busy}), 64'(3'b010));
    nxt_tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus();
      if (done) done_cnt++;
      if (dat_oe) oe_cnt++;
    end
    check_output("rst_no_done", 64'(done_cnt), 64'd0);
    check_output("rst_oe_low", 64'(oe_cnt), 64'd0);
    reset       = 1'b1;
    exp_rx_data = 32'h0;
    words.delete();
    words.push_back($urandom);
    run_read(4'd1, 1'b0, 1);
  endtask

  task automatic fill(input int n, input int max_stall);
    words.delete();
    stalls.delete();
    for (int i = 0; i < n; i++) begin
      words.push_back($urandom);
      stalls.push_back(int'($urandom_range(max_stall, 0)));
    end
  endtask

  vec_t vecs[8];

  initial begin
    int blk_r, mult_r, tgt_r, bad_r;

    reset = 1'b0;
    start_read = 1'b0; start_write = 1'b0; blocks = 4'd0; multiple = 1'b0;
    timeout_reg = 16'd0; tx_data = 32'h0; tx_valid = 1'b0; dat_in = 1'b1;

    repeat (3) @(negedge sd_clock);
    check_output("reset_dat", 64'({dat_out, dat_oe}), 64'(2'b10));
    check_output("reset_pulses", 64'({tx_ready, rx_valid, done, frame_error, timeout}), 64'(5'b0));
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_rx_data", 64'(rx_data), 64'd0);
    reset = 1'b1;
    @(negedge sd_clock);

    // Single read of a fixed word.
    words.delete(); stalls.delete();
    words.push_back(32'hDEADBEEF); stalls.push_back(0);
    run_read(4'd1, 1'b0, 1);

    // Three-block read with a 5-cycle supply stall before block 2.
    fill(3, 0);
    stalls[0] = 5;
    run_read(4'd3, 1'b1, 3);

    // Two good write blocks.
    words.delete(); stalls.delete();
    words.push_back(32'h12345678); words.push_back(32'hA5A5A5A5);
    stalls.push_back(0); stalls.push_back(3);
    run_write(4'd2, 1'b1, 2, -1);

    // Bad end bit on block 1 of 3 aborts the transfer.
    fill(3, 2);
    run_write(4'd3, 1'b1, 3, 0);

    run_timeout(16'd20);
    run_timeout(16'd0);

    reset_mid_frame();

    // Block-target rule across read and write.
    vecs[0] = '{1'b0, 4'd1,  1'b0, 1};
    vecs[1] = '{1'b0, 4'd3,  1'b1, 3};
    vecs[2] = '{1'b0, 4'd0,  1'b1, 1};
    vecs[3] = '{1'b0, 4'd5,  1'b0, 1};
    vecs[4] = '{1'b1, 4'd2,  1'b1, 2};
    vecs[5] = '{1'b1, 4'd0,  1'b1, 1};
    vecs[6] = '{1'b1, 4'd4,  1'b0, 1};
    vecs[7] = '{1'b0, 4'd15, 1'b1, 15};
    for (int v = 0; v < 8; v++) begin
      fill(vecs[v].exp_blocks, 0);
      if (vecs[v].is_write) run_write(vecs[v].blk, vecs[v].mult, vecs[v].exp_blocks, -1);
      else                  run_read(vecs[v].blk, vecs[v].mult, vecs[v].exp_blocks);
    end

    // Randomised transfers.
    for (int r = 0; r < 6; r++) begin
      blk_r  = int'($urandom_range(5, 0));
      mult_r = int'($urandom_range(1, 0));
      tgt_r  = (mult_r != 0 && blk_r != 0) ? blk_r : 1;
      fill(tgt_r, 6);
      run_read(4'(blk_r), 1'(mult_r), tgt_r);
    end
    for (int r = 0; r < 6; r++) begin
      blk_r  = int'($urandom_range(5, 0));
      mult_r = int'($urandom_range(1, 0));
      tgt_r  = (mult_r != 0 && blk_r != 0) ? blk_r : 1;
      bad_r  = ($urandom_range(2, 0) == 0) ? int'($urandom_range(tgt_r - 1, 0)) : -1;
      fill(tgt_r, 4);
      run_write(4'(blk_r), 1'(mult_r), tgt_r, bad_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
